// File: rtl/bitwise_logic_pipe.sv
// Pipelined bitwise logic unit: eight two-operand/one-operand bitwise ops with
// valid/ready handshakes on both sides, a zero flag and a delivered-result counter.
module bitwise_logic_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] count
);

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_NOR  = 3'b101;
  localparam logic [2:0] OP_XNOR = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [WIDTH-1:0] result_d;
  logic             zero_d;
  logic             advance;
  logic             out_hs;
  logic [CNT_W-1:0] count_d;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] zero_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    result_d = a;
    unique case (op)
      OP_NOT:  result_d = ~a;
      OP_AND:  result_d = a & b;
      OP_OR:   result_d = a | b;
      OP_XOR:  result_d = a ^ b;
      OP_NAND: result_d = ~(a & b);
      OP_NOR:  result_d = ~(a | b);
      OP_XNOR: result_d = ~(a ^ b);
      OP_PASS: result_d = a;
      default: result_d = a;
    endcase
  end

  assign zero_d  = ~|result_d;
  assign advance = ~out_valid | out_ready;
  assign in_ready = advance & ~rst;
  assign out_hs  = out_valid & out_ready;
  assign count_d = count_q + CNT_W'(1);

  // The whole pipe shifts as one unit; empty slots are not squeezed out.
  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      zero_q  <= '0;
      count_q <= '0;
      // NOTE: the data stages are cleared on reset because y must read zero out of reset.
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else begin
      if (advance) begin
        valid_q[0] <= in_valid;
        data_q[0]  <= result_d;
        zero_q[0]  <= zero_d;
        for (int k = 1; k < DEPTH; k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
          zero_q[k]  <= zero_q[k-1];
        end
      end
      if (out_hs) count_q <= count_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign y         = data_q[DEPTH-1];
  assign zero      = zero_q[DEPTH-1];
  assign count     = count_q;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Directed self-checking bench for bitwise_logic_pipe (WIDTH=8, DEPTH=2, CNT_W=4).
module tb_bitwise_logic_pipe;

  localparam int W  = 8;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic          zero;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] got_y [$];
  logic         got_z [$];

  bitwise_logic_pipe #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .count(count)
  );

  always #5 clk = ~clk;

  // Every delivered result is logged mid-cycle, ahead of the edge that completes it.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_y.push_back(y);
      got_z.push_back(zero);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    repeat (D + 2) tick();
  endtask

  logic [W-1:0] exp_ops [8] = '{8'h5A, 8'h24, 8'hBD, 8'h99, 8'hDB, 8'h42, 8'h66, 8'hA5};
  logic [W-1:0] exp_bp  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  initial begin
    int base;
    int hs;
    logic hs_now;

    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'h00; op = 3'b000; out_ready = 1'b1;

    // Reset behaviour
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_y", y, 0);
      check("rst_zero", zero, 0);
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 0);
    end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    repeat (2) begin
      tick();
      check("post_rst_no_output", out_valid, 0);
    end

    // All opcodes back to back, with the first result after DEPTH-1 further edges
    for (int i = 0; i < 8; i++) begin
      a = 8'hA5; b = 8'h3C; op = 3'(i); in_valid = 1'b1;
      tick();
      if (i == 0) check("latency_first_not_yet", out_valid, 0);
      if (i == 1) begin
        check("latency_first_valid", out_valid, 1);
        check("latency_first_y", y, 8'h5A);
      end
    end
    drain();
    check("ops_n_results", got_y.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_y.size()) begin
        check($sformatf("op%0d_y", i), got_y[i], exp_ops[i]);
        check($sformatf("op%0d_zero", i), got_z[i], 0);
      end
    end
    check("ops_count", count, 8);

    // Zero flag from NOT and from AND
    base = got_y.size();
    a = 8'hFF; b = 8'h00; op = 3'b000; in_valid = 1'b1; tick();
    a = 8'h0F; b = 8'hF0; op = 3'b001; tick();
    drain();
    check("zero_n_results", got_y.size(), base + 2);
    for (int i = 0; i < 2; i++) begin
      if (base + i < got_y.size()) begin
        check($sformatf("zero%0d_y", i), got_y[base+i], 0);
        check($sformatf("zero%0d_flag", i), got_z[base+i], 1);
      end
    end
    check("zero_count", count, 10);

    // Backpressure: stall three cycles with the pipe full
    base = got_y.size();
    out_ready = 1'b0; op = 3'b111; b = 8'h00; in_valid = 1'b1;
    a = 8'h11; tick();
    a = 8'h22; tick();
    a = 8'h33; #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_y", y, 8'h11);
      check("stall_in_ready", in_ready, 0);
      check("stall_count", count, 10);
      tick();
    end
    out_ready = 1'b1; #1;
    check("unstall_in_ready", in_ready, 1);
    tick();
    a = 8'h44; tick();
    drain();
    check("bp_n_results", got_y.size(), base + 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < got_y.size())
        check($sformatf("bp%0d_y", i), got_y[base+i], exp_bp[i]);
    end
    check("bp_count", count, 14);

    // Reset with two results in flight
    base = got_y.size();
    op = 3'b111; in_valid = 1'b1;
    a = 8'h01; tick();
    a = 8'h02; tick();
    rst = 1'b1; in_valid = 1'b0; #1;
    check("midrst_in_ready", in_ready, 0);
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_count", count, 0);
    rst = 1'b0; a = 8'h00; op = 3'b000; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst_new_valid", out_valid, 1);
    check("midrst_new_y", y, 8'hFF);
    check("midrst_new_zero", zero, 0);
    drain();
    check("midrst_n_results", got_y.size(), base + 1);
    if (base < got_y.size()) check("midrst_only_new", got_y[base], 8'hFF);

    // Counter wrap: 17 handshakes from a freshly reset counter
    rst = 1'b1; tick(); rst = 1'b0;
    check("wrap_start", count, 0);
    hs = 0;
    for (int i = 0; i < 17 + D + 2; i++) begin
      in_valid = (i < 17); a = 8'(i); op = 3'b111;
      #1;
      hs_now = out_valid && out_ready;
      tick();
      if (hs_now) begin
        hs++;
        if (hs == 15) check("wrap_15", count, 15);
        if (hs == 16) check("wrap_16", count, 0);
        if (hs == 17) check("wrap_17", count, 1);
      end
    end
    check("wrap_handshakes", hs, 17);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_pipe.md
# bitwise_logic_pipe

Parametrised, pipelined bitwise logic unit: the multi-bit, multi-operation, registered successor to the single-bit inverter. Takes WIDTH-bit operands A and B plus a 3-bit opcode through a valid/ready input handshake. Delivers the result after DEPTH register stages with valid/ready backpressure, a zero flag, and a running count of delivered results. It sits between the lab operand-source logic and the lab datapath, ALU, or display consumer.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 2, number of pipeline register stages (≥1); equals latency
- CNT_W, 16, width of the delivered-result counter (≥1)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand bundle valid
- in_ready  output  1  unit accepts a bundle this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored for NOT/PASS)
- op  input  3  operation select
- out_valid  output  1  y/zero hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- y  output  WIDTH  result
- zero  output  1  1 when the y of the valid result is all zeros
- count  output  CNT_W  number of completed output handshakes, modulo 2^CNT_W

## Operation

- Opcodes:
  - 000 y = ~a
  - 001 a & b
  - 010 a | b
  - 011 a ^ b
  - 100 ~(a & b)
  - 101 ~(a | b)
  - 110 ~(a ^ b)
  - 111 a (pass)
- The result is computed combinationally from a/b/op and captured into stage 1. The zero flag is computed from that result and travels with it.
- Each stage holds {valid, data, zero}. Stage DEPTH drives out_valid/y/zero.
- advance = ~out_valid | out_ready. The pipeline moves as one unit; there is no bubble collapse.
- When advance = 1:
  - stage 1 loads {in_valid, result, zero}
  - stage k loads stage k-1
- When advance = 0: all stages hold.
- in_ready = advance & ~rst (combinational). An input is accepted when in_valid & in_ready.
- An output handshake is out_valid & out_ready. Each handshake increments count by 1, wrapping from 2^CNT_W−1 to 0.
- Data registers load on advance even when the incoming valid is 0. Contents of invalid slots are don't-care and must not be checked.
- op, a and b are sampled only in a cycle where in_valid & in_ready.

## Timing

- Reset (rst = 1 at a rising edge) has these effects on the following cycle:
  - all stage valids = 0
  - all data = 0
  - all zero bits = 0
  - count = 0
  - outputs: out_valid = 0, y = 0, zero = 0, count = 0
  - in_ready = 0 while rst is high, then 1 in the first cycle after rst drops (pipe empty)
- Latency: a bundle accepted at edge N appears with out_valid = 1 after edge N+DEPTH−1, provided there are no stalls. With DEPTH = 1, the result is visible in the cycle after acceptance.
- Throughput: one result per cycle while out_ready = 1.
- Backpressure:
  - out_valid = 1 with out_ready = 0 freezes every stage, y, zero and count.
  - in_ready drops in the same cycle.
  - No data is lost or duplicated.
- An output handshake and an input acceptance in the same cycle are legal and required for full throughput.
- Reset mid-operation discards all in-flight results with no output handshake, and count is cleared. Reset has priority over advance and over the count increment.
- count updates at the edge that completes the handshake. It is visible in the following cycle.

## Test plan

- Reset values: assert rst for 2 cycles with in_valid = 1, a = FF. Required: out_valid = 0, y = 00, zero = 0, count = 0, in_ready = 0 during reset. After release, in_ready = 1 and no output appears.
- All opcodes (WIDTH = 8, DEPTH = 2, out_ready = 1): a = A5, b = 3C, op = 0..7 on consecutive cycles. Required outputs, in order, starting 2 cycles after the first acceptance: 5A, 24, BD, 99, DB, 42, 66, A5, with zero = 0 each time. count = 8 afterwards.
- Zero flag: a = FF, op = 000. Required: y = 00, zero = 1. Then a = 0F, b = F0, op = 001. Required: y = 00, zero = 1.
- Backpressure: stream 4 bundles with out_ready = 0 from the first out_valid onwards for 3 cycles. Required: y held stable, in_ready = 0 and count unchanged during the stall. After out_ready = 1, all 4 results arrive in order with no loss or duplication.
- Counter wrap (CNT_W = 4): deliver 17 results. Required: count reads 15 after 15 handshakes, 0 after 16, and 1 after 17.
- Reset mid-stream: with 2 results in flight, assert rst for one cycle. Required: out_valid = 0 and count = 0 next cycle, and the in-flight results never appear. A new bundle a = 00, op = 000 yields y = FF after DEPTH cycles.
